// File: rtl/cdc_hndshk_pkg.sv
// Shared types and constants for the toggle-based CDC handshake endpoints.
package cdc_hndshk_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } dest_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer; only the first flop samples the asynchronous input.
module cdc_sync_bit
  import cdc_hndshk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hndshk_dest.sv
// Destination endpoint of the toggle CDC handshake: presents each request toggle as one
// strobe under backpressure and returns an acknowledge toggle once it is consumed.
module cdc_hndshk_dest
  import cdc_hndshk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               dest_clk,
  input  logic               dest_reset_n,
  input  logic               req_tgl,
  output logic               ack_tgl,
  output logic               dest_strobe,
  input  logic               dest_stall,
  output logic [COUNT_W-1:0] event_count,
  output logic               proto_err
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("cdc_hndshk_dest: SYNC_STAGES out of range");
  end

  logic        req_sync;
  logic        req_seen;
  dest_state_e state;
  dest_state_e state_nxt;
  logic        accept_c;
  logic        dbl_tgl_c;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (dest_clk),
    .rst_n(dest_reset_n),
    .d    (req_tgl),
    .q    (req_sync)
  );

  // Next state and event decode
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    dbl_tgl_c = 1'b0;
    case (state)
      IDLE: begin
        if (req_sync != req_seen) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        // Level returning to req_seen before consumption means a toggle was lost
        dbl_tgl_c = (req_sync == req_seen);
        if (!dest_stall) begin
          accept_c  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      state       <= IDLE;
      dest_strobe <= 1'b0;
      req_seen    <= 1'b0;
      ack_tgl     <= 1'b0;
      event_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      dest_strobe <= (state_nxt == PRESENT);
      req_seen    <= req_seen ^ accept_c;
      ack_tgl     <= ack_tgl ^ accept_c;
      if (accept_c) begin
        event_count <= event_count + COUNT_W'(1);
      end
      proto_err   <= proto_err | dbl_tgl_c;
    end
  end

endmodule

// File: tb/tb_cdc_hndshk_dest.sv
// Self-checking bench for cdc_hndshk_dest: event-level reference model plus directed scenarios.
module tb_cdc_hndshk_dest;

  localparam int unsigned SS  = 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 4;

  logic           dest_clk     = 1'b0;
  logic           dest_reset_n = 1'b0;
  logic           req_tgl      = 1'b0;
  logic           dest_stall   = 1'b0;
  logic           ack_tgl;
  logic           dest_strobe;
  logic [CW-1:0]  event_count;
  logic           proto_err;
  logic           ack_w;
  logic           strobe_w;
  logic [CWS-1:0] count_w;
  logic           err_w;

  always #5 dest_clk = ~dest_clk;

  cdc_hndshk_dest #(.SYNC_STAGES(SS), .COUNT_W(CW)) u_dut (
    .dest_clk    (dest_clk),
    .dest_reset_n(dest_reset_n),
    .req_tgl     (req_tgl),
    .ack_tgl     (ack_tgl),
    .dest_strobe (dest_strobe),
    .dest_stall  (dest_stall),
    .event_count (event_count),
    .proto_err   (proto_err)
  );

  // Narrow-counter copy on the same inputs, so counter wrap is reachable quickly
  cdc_hndshk_dest #(.SYNC_STAGES(SS), .COUNT_W(CWS)) u_dut_w (
    .dest_clk    (dest_clk),
    .dest_reset_n(dest_reset_n),
    .req_tgl     (req_tgl),
    .ack_tgl     (ack_w),
    .dest_strobe (strobe_w),
    .dest_stall  (dest_stall),
    .event_count (count_w),
    .proto_err   (err_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request level as seen SS edges late, events accepted so far,
  // whether an event is on offer, and the sticky error.
  bit     hist[$];
  longint m_acc;
  bit     m_present;
  bit     m_err;
  bit     prev_ack    = 1'b0;
  bit     prev_strobe = 1'b0;
  int     hi_cnt      = 0;
  int     rise_cnt    = 0;
  int     ack_edges   = 0;

  always @(posedge dest_clk) begin
    bit rs;
    bit seen;
    if (!dest_reset_n) begin
      hist.delete();
      for (int i = 0; i < int'(SS); i++) hist.push_back(1'b0);
      m_acc     = 0;
      m_present = 1'b0;
      m_err     = 1'b0;
    end else begin
      rs   = hist[SS-1];
      seen = m_acc[0];
      if (m_present) begin
        if (rs == seen) m_err = 1'b1;
        if (!dest_stall) begin
          m_acc     = m_acc + 1;
          m_present = 1'b0;
        end
      end else if (rs != seen) begin
        m_present = 1'b1;
      end
      hist.push_front(req_tgl);
      void'(hist.pop_back());
    end
    #1;
    chk("strobe", 64'(dest_strobe), 64'(m_present));
    chk("ack", 64'(ack_tgl), 64'(m_acc[0]));
    chk("count", 64'(event_count), 64'(m_acc[CW-1:0]));
    chk("proto_err", 64'(proto_err), 64'(m_err));
    chk("strobe_w", 64'(strobe_w), 64'(m_present));
    chk("ack_w", 64'(ack_w), 64'(m_acc[0]));
    chk("count_w", 64'(count_w), 64'(m_acc[CWS-1:0]));
    chk("proto_err_w", 64'(err_w), 64'(m_err));
    if (dest_strobe) hi_cnt++;
    if (dest_strobe && !prev_strobe) rise_cnt++;
    if (ack_tgl != prev_ack) ack_edges++;
    prev_strobe = dest_strobe;
    prev_ack    = ack_tgl;
  end

  task automatic do_reset();
    @(negedge dest_clk);
    dest_reset_n = 1'b0;
    req_tgl      = 1'b0;
    dest_stall   = 1'b0;
    repeat (2) @(negedge dest_clk);
    dest_reset_n = 1'b1;
  endtask

  task automatic wait_strobe(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge dest_clk);
      if (dest_strobe) break;
    end
    chk(name, 64'(dest_strobe), 64'd1);
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 50; i++) begin
      if (ack_tgl == req_tgl) break;
      @(negedge dest_clk);
    end
    chk(name, 64'(ack_tgl), 64'(req_tgl));
  endtask

  initial begin
    int lat;

    // 1: reset, idle 50 cycles
    @(negedge dest_clk);
    chk("rst_count", 64'(event_count), 64'd0);
    repeat (2) @(negedge dest_clk);
    dest_reset_n = 1'b1;
    hi_cnt = 0;
    repeat (50) @(negedge dest_clk);
    chk("idle_strobe_cycles", 64'(hi_cnt), 64'd0);
    chk("idle_ack", 64'(ack_tgl), 64'd0);
    chk("idle_count", 64'(event_count), 64'd0);
    chk("idle_err", 64'(proto_err), 64'd0);

    // 2: single event, no stall
    do_reset();
    @(negedge dest_clk);
    hi_cnt  = 0;
    req_tgl = 1'b1;
    lat     = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge dest_clk);
      #2;
      if (dest_strobe) begin
        lat = i;
        break;
      end
    end
    chk("latency_edges", 64'(lat), 64'd3);
    repeat (5) @(negedge dest_clk);
    chk("s2_strobe_cycles", 64'(hi_cnt), 64'd1);
    chk("s2_ack", 64'(ack_tgl), 64'd1);
    chk("s2_count", 64'(event_count), 64'd1);

    // 3: stalled event held 11 cycles
    do_reset();
    @(negedge dest_clk);
    dest_stall = 1'b1;
    hi_cnt     = 0;
    req_tgl    = 1'b1;
    wait_strobe("s3_strobe_wait");
    chk("s3_count_stalled", 64'(event_count), 64'd0);
    repeat (10) @(negedge dest_clk);
    chk("s3_ack_stalled", 64'(ack_tgl), 64'd0);
    dest_stall = 1'b0;
    repeat (3) @(negedge dest_clk);
    chk("s3_strobe_cycles", 64'(hi_cnt), 64'd11);
    chk("s3_count", 64'(event_count), 64'd1);
    chk("s3_ack", 64'(ack_tgl), 64'd1);

    // 4: source double-toggles while an event is pending
    do_reset();
    @(negedge dest_clk);
    dest_stall = 1'b1;
    rise_cnt   = 0;
    req_tgl    = 1'b1;
    wait_strobe("s4_strobe_wait");
    @(negedge dest_clk);
    req_tgl = 1'b0;
    @(negedge dest_clk);
    req_tgl = 1'b1;
    repeat (5) @(negedge dest_clk);
    chk("s4_err", 64'(proto_err), 64'd1);
    dest_stall = 1'b0;
    repeat (5) @(negedge dest_clk);
    chk("s4_strobes", 64'(rise_cnt), 64'd1);
    chk("s4_count", 64'(event_count), 64'd1);
    repeat (100) @(negedge dest_clk);
    chk("s4_err_sticky", 64'(proto_err), 64'd1);

    // 5: reset while presenting under stall
    do_reset();
    @(negedge dest_clk);
    req_tgl = 1'b1;
    wait_ack("s5_first_ack");
    dest_stall = 1'b1;
    req_tgl    = 1'b0;
    wait_strobe("s5_strobe_wait");
    chk("s5_pre_count", 64'(event_count), 64'd1);
    #2;
    dest_reset_n = 1'b0;
    req_tgl      = 1'b0;
    #1;
    chk("s5_rst_strobe", 64'(dest_strobe), 64'd0);
    chk("s5_rst_ack", 64'(ack_tgl), 64'd0);
    chk("s5_rst_count", 64'(event_count), 64'd0);
    repeat (2) @(negedge dest_clk);
    dest_reset_n = 1'b1;
    dest_stall   = 1'b0;
    hi_cnt       = 0;
    repeat (30) @(negedge dest_clk);
    chk("s5_no_strobe", 64'(hi_cnt), 64'd0);

    // 7: unconstrained random toggles and stall, model-checked every cycle
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge dest_clk);
      if ($urandom_range(0, 5) == 0) req_tgl = ~req_tgl;
      dest_stall = ($urandom_range(0, 3) == 0);
    end
    dest_stall = 1'b0;
    repeat (10) @(negedge dest_clk);

    // 6: well-behaved handshakes with random stall; narrow counter wraps
    do_reset();
    @(negedge dest_clk);
    ack_edges = 0;
    for (int i = 0; i < 2000; i++) begin
      req_tgl = ~req_tgl;
      for (int c = 0; c < 60; c++) begin
        if (ack_tgl == req_tgl) break;
        dest_stall = ($urandom_range(0, 2) == 0);
        @(negedge dest_clk);
      end
      chk("s6_hs_ack", 64'(ack_tgl), 64'(req_tgl));
      dest_stall = 1'b0;
      if (i == 14) chk("s6_count_w_15", 64'(count_w), 64'd15);
      if (i == 15) chk("s6_count_w_wrap", 64'(count_w), 64'd0);
      repeat ($urandom_range(0, 2)) @(negedge dest_clk);
    end
    repeat (3) @(negedge dest_clk);
    chk("s6_ack_edges", 64'(ack_edges), 64'd2000);
    chk("s6_count", 64'(event_count), 64'd2000);
    chk("s6_count_w", 64'(count_w), 64'd0);
    chk("s6_err", 64'(proto_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
